// File: rtl/deserializer_15to30.sv
// 15-bit to 30-bit receive gearbox. Pairs half-words into TMDS symbol words
// and recovers pair alignment by slipping one half-word, either on request
// or automatically while hunting for control tokens on channel 0.
module deserializer_15to30 #(
  parameter int unsigned WINDOW_LEN = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] data_in,
  input  logic        din_valid,
  input  logic        slip,
  input  logic        auto_align,
  output logic [29:0] data_out,
  output logic        dout_valid,
  output logic        locked
);

  localparam int unsigned HALF_W = 15;
  localparam int unsigned WORD_W = 2 * HALF_W;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 1);

  localparam logic [SYM_W-1:0] TOK0 = 10'h354;
  localparam logic [SYM_W-1:0] TOK1 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK2 = 10'h154;
  localparam logic [SYM_W-1:0] TOK3 = 10'h2AB;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // datapath state
  logic              phase_q, phase_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic              slip_pend_q, slip_pend_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              dout_valid_q, dout_valid_d;

  // alignment FSM state
  logic [0:0]        state_q, state_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic              seen_q, seen_d;

  logic [SYM_W-1:0]  ch0_sym_c;
  logic              token_c;
  logic              seen_now_c;
  logic              win_end_c;
  logic              fsm_slip_c;
  logic              slip_req_c;

  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;

  // Token match on the word currently presented with its strobe
  assign ch0_sym_c  = {data_out_q[19:15], data_out_q[4:0]};
  assign token_c    = dout_valid_q &&
                      ((ch0_sym_c == TOK0) || (ch0_sym_c == TOK1) ||
                       (ch0_sym_c == TOK2) || (ch0_sym_c == TOK3));
  assign seen_now_c = seen_q | token_c;
  assign win_end_c  = auto_align && dout_valid_q && (win_cnt_q == WIN_LAST);

  // Alignment FSM: window bookkeeping and lock/slip decision at window end
  always_comb begin
    state_d    = state_q;
    locked_d   = locked_q;
    win_cnt_d  = win_cnt_q;
    seen_d     = seen_q;
    fsm_slip_c = 1'b0;
    if (!auto_align) begin
      state_d   = ST_SEARCH;
      locked_d  = 1'b0;
      win_cnt_d = '0;
      seen_d    = 1'b0;
    end else if (dout_valid_q) begin
      if (win_end_c) begin
        win_cnt_d = '0;
        seen_d    = 1'b0;
        case (state_q)
          ST_SEARCH: begin
            if (seen_now_c) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              fsm_slip_c = 1'b1;
            end
          end
          default: begin
            if (!seen_now_c) begin
              state_d  = ST_SEARCH;
              locked_d = 1'b0;
            end
          end
        endcase
      end else begin
        win_cnt_d = win_cnt_q + CNT_W'(1);
        seen_d    = seen_now_c;
      end
    end
  end

  // Half-word pairing with single-shot slip (drop one accepted half-word)
  always_comb begin
    phase_d      = phase_q;
    lo_d         = lo_q;
    data_out_d   = data_out_q;
    dout_valid_d = 1'b0;
    slip_pend_d  = slip_pend_q;
    slip_req_c   = slip | fsm_slip_c;
    if (din_valid) begin
      if (slip_pend_q) begin
        slip_pend_d = 1'b0;
      end else if (!phase_q) begin
        lo_d    = data_in;
        phase_d = 1'b1;
      end else begin
        data_out_d   = {data_in, lo_q};
        dout_valid_d = 1'b1;
        phase_d      = 1'b0;
      end
    end
    if (!slip_pend_q && slip_req_c) begin
      slip_pend_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      lo_q         <= '0;
      slip_pend_q  <= 1'b0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
      state_q      <= ST_SEARCH;
      locked_q     <= 1'b0;
      win_cnt_q    <= '0;
      seen_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      lo_q         <= lo_d;
      slip_pend_q  <= slip_pend_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
      state_q      <= state_d;
      locked_q     <= locked_d;
      win_cnt_q    <= win_cnt_d;
      seen_q       <= seen_d;
    end
  end

endmodule

// File: tb/tb_deserializer_15to30.sv
// Bench for deserializer_15to30: word-level reference model plus literal checks.
module tb_deserializer_15to30;

  localparam int unsigned WL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] data_in;
  logic        din_valid;
  logic        slip;
  logic        auto_align;
  logic [29:0] data_out;
  logic        dout_valid;
  logic        locked;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  deserializer_15to30 #(.WINDOW_LEN(WL)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .din_valid(din_valid),
    .slip(slip), .auto_align(auto_align), .data_out(data_out),
    .dout_valid(dout_valid), .locked(locked)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit is_tok(input logic [29:0] w);
    int s;
    s = int'(w >> 15) % 32 * 32 + int'(w % 30'd32);
    return (s == 'h354) || (s == 'h0AB) || (s == 'h154) || (s == 'h2AB);
  endfunction

  // Reference model: what the DUT must show after each edge
  logic [14:0] m_hold = '0;
  bit          m_have = 0;
  bit          m_drop = 0;
  bit          m_vld  = 0;
  logic [29:0] m_word = '0;
  int          m_cnt  = 0;
  bit          m_seen = 0;
  bit          m_lock = 0;
  int          m_fsm_slips = 0;
  bit          m_fslip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = '0; m_have = 0; m_drop = 0; m_vld = 0; m_word = '0;
      m_cnt = 0; m_seen = 0; m_lock = 0;
    end else begin
      m_fslip = 0;
      if (!auto_align) begin
        m_cnt = 0; m_seen = 0; m_lock = 0;
      end else if (m_vld) begin
        m_cnt++;
        if (is_tok(m_word)) m_seen = 1;
        if (m_cnt == int'(WL)) begin
          if (m_lock) m_lock = m_seen;
          else if (m_seen) m_lock = 1;
          else m_fslip = 1;
          m_cnt = 0; m_seen = 0;
        end
      end
      if (m_fslip) m_fsm_slips++;
      m_vld = 0;
      if (din_valid && m_drop) begin
        m_drop = 0;
      end else begin
        if (din_valid) begin
          if (!m_have) begin
            m_hold = data_in; m_have = 1;
          end else begin
            m_word = {data_in, m_hold}; m_vld = 1; m_have = 0;
          end
        end
        if (slip || m_fslip) m_drop = 1;
      end
    end
  end

  // Per-cycle compare against the model, and a log of delivered words
  logic [29:0] got_q[$];
  always @(negedge clk) begin
    check("dout_valid", 32'(dout_valid), 32'(m_vld));
    check("data_out", 32'(data_out), 32'(m_word));
    check("locked", 32'(locked), 32'(m_lock));
    if (dout_valid) got_q.push_back(data_out);
  end

  task automatic put(input logic [14:0] h, input int gap, input bit sl);
    repeat (gap) begin
      @(negedge clk); din_valid = 1'b0; slip = 1'b0;
    end
    @(negedge clk); data_in = h; din_valid = 1'b1; slip = sl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); din_valid = 1'b0; slip = 1'b0;
    end
  endtask

  task automatic send_word(input int tok, input int gap, output logic [29:0] w);
    logic [9:0] c0, c1, c2;
    c1 = 10'($urandom);
    c2 = 10'($urandom);
    if (tok == 1) c0 = 10'h354;
    else if (tok == 0) c0 = 10'h000;
    else c0 = 10'($urandom);
    w = {c2[9:5], c1[9:5], c0[9:5], c2[4:0], c1[4:0], c0[4:0]};
    put(w[14:0], gap, 1'b0);
    put(w[29:15], gap, 1'b0);
  endtask

  logic [14:0] seq [4];
  logic [14:0] ha, hb, hc, hd, he;
  logic [29:0] w, wl;
  int          s0;

  initial begin
    rst_n = 1'b0; data_in = '0; din_valid = 1'b0; slip = 1'b0; auto_align = 1'b0;
    seq[0] = 15'h0001; seq[1] = 15'h7FFE; seq[2] = 15'h1234; seq[3] = 15'h4321;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // basic pairing, back to back
    got_q.delete();
    for (int i = 0; i < 4; i++) put(seq[i], 0, 1'b0);
    idle(2);
    check("basic_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("basic_w0", 32'(got_q[0]), 32'h3FFF0001);
      check("basic_w1", 32'(got_q[1]), 32'h21909234);
    end

    // same sequence with random gaps
    got_q.delete();
    for (int i = 0; i < 4; i++) put(seq[i], int'($urandom_range(0, 5)), 1'b0);
    idle(2);
    check("gap_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("gap_w0", 32'(got_q[0]), 32'h3FFF0001);
      check("gap_w1", 32'(got_q[1]), 32'h21909234);
    end

    // manual slip drops A; pairing continues from B
    ha = 15'h1111; hb = 15'h2222; hc = 15'h3333; hd = 15'h4444; he = 15'h5555;
    got_q.delete();
    @(negedge clk); din_valid = 1'b0; slip = 1'b1;
    put(ha, 0, 1'b0); put(hb, 0, 1'b0); put(hc, 0, 1'b0);
    put(hd, 1, 1'b0); put(he, 0, 1'b0);
    idle(2);
    check("slip_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("slip_w0", 32'(got_q[0]), 32'({hc, hb}));
      check("slip_w1", 32'(got_q[1]), 32'({he, hd}));
    end

    // auto-alignment from a stream one half-word off
    @(negedge clk); auto_align = 1'b1; din_valid = 1'b0;
    s0 = m_fsm_slips;
    got_q.delete();
    put(15'h0000, 0, 1'b0);
    for (int k = 0; k < 24; k++) send_word((k % 4 == 0) ? 1 : 0, 0, wl);
    idle(2);
    check("align_slips", 32'(m_fsm_slips - s0), 32'd1);
    check("align_locked", 32'(locked), 32'd1);
    if (got_q.size() > 0) check("align_last", 32'(got_q[$]), 32'(wl));

    // lock loss: no slip on the losing window, slip on the next empty one
    s0 = m_fsm_slips;
    for (int k = 0; k < 8; k++) send_word(0, 0, w);
    idle(2);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_noslip", 32'(m_fsm_slips - s0), 32'd0);
    for (int k = 0; k < 8; k++) send_word(0, 0, w);
    idle(2);
    check("loss_slip", 32'(m_fsm_slips - s0), 32'd1);

    // reset mid-window and mid-pair while locked
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    for (int k = 0; k < 8; k++) send_word(1, 0, w);
    idle(2);
    check("relock", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) send_word(0, 0, w);
    put(15'h2AAA, 0, 1'b0);
    #2; rst_n = 1'b0; din_valid = 1'b0;
    #1;
    check("async_data_out", 32'(data_out), 32'h0);
    check("async_dout_valid", 32'(dout_valid), 32'h0);
    check("async_locked", 32'(locked), 32'h0);
    idle(2);
    rst_n = 1'b1;
    got_q.delete();
    put(ha, 0, 1'b0); put(hb, 0, 1'b0);
    idle(2);
    check("post_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("post_rst_w", 32'(got_q[0]), 32'({hb, ha}));

    // drop auto_align while locked
    for (int k = 0; k < 8; k++) send_word(1, 0, w);
    idle(2);
    check("lock_before_drop", 32'(locked), 32'd1);
    @(negedge clk); auto_align = 1'b0;
    @(negedge clk);
    check("drop_locked", 32'(locked), 32'd0);
    s0 = m_fsm_slips;
    for (int k = 0; k < 20; k++) send_word(0, 0, wl);
    idle(2);
    check("disabled_noslip", 32'(m_fsm_slips - s0), 32'd0);
    if (got_q.size() > 0) check("disabled_last", 32'(got_q[$]), 32'(wl));

    // randomized traffic: gaps, slips, auto_align toggles, mixed tokens
    auto_align = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 3) begin
        @(negedge clk); din_valid = 1'b0; slip = 1'b1;
      end
      if ($urandom_range(0, 99) < 2) auto_align = ~auto_align;
      send_word(($urandom_range(0, 3) == 0) ? 1 : 2,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, w);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
